// File: rtl/nibbler_pkg.sv
// nibbler_pkg
// Shared types and constants for the nibble-wide CPU datapath.
//   nibble_t        4-bit data-bus nibble
//   OUT_FIFO_DEPTH  default entry count of the output-port FIFO
package nibbler_pkg;

  typedef logic [3:0] nibble_t;

  localparam int OUT_FIFO_DEPTH = 4;

endpackage : nibbler_pkg

// File: rtl/nibble_regfile.sv
// nibble_regfile
// Storage array for the output-port FIFO. It has one synchronous write port
// and one asynchronous read port. There is no reset, because the FIFO hides
// stale entries by gating its output with its occupancy count.
// Ports:
//   clk    in   write clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  read data (combinational)
module nibble_regfile
  import nibbler_pkg::*;
#(
  parameter int DEPTH = OUT_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  nibble_t                  wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output nibble_t                  rdata
);

  nibble_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : nibble_regfile

// File: rtl/out_port_fifo.sv
// out_port_fifo
// First-word-fall-through FIFO between the CPU output strobe and an external
// consumer that uses a valid/ready handshake. A push into a full FIFO is
// dropped and recorded in a sticky overflow flag, unless a pop happens in the
// same cycle and frees the slot.
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   loadOut    in   push request for bus
//   bus        in   nibble to push (ignored while loadOut=0)
//   out_valid  out  head entry available
//   out_data   out  head entry (0 when empty)
//   out_ready  in   consumer takes the head this cycle
//   count      out  occupied entries, 0..DEPTH
//   full       out  count==DEPTH
//   overflow   out  sticky flag: a push was dropped
//   clr_ovf    in   synchronous clear of overflow
module out_port_fifo
  import nibbler_pkg::*;
#(
  parameter int DEPTH = OUT_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   loadOut,
  input  nibble_t                bus,
  output logic                   out_valid,
  output nibble_t                out_data,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   overflow,
  input  logic                   clr_ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          drop;
  nibble_t       head;

  assign out_valid = (count != '0);
  assign full      = (count == DEPTH_C);
  assign pop       = out_valid & out_ready;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push      = loadOut & (~full | pop);
  assign drop      = loadOut & full & ~pop;

  nibble_regfile #(
    .DEPTH (DEPTH)
  ) u_regfile (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (bus),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Memory is not reset, so stale contents are masked while the FIFO is empty.
  assign out_data = out_valid ? head : '0;

  // DEPTH is a power of two, so the pointers wrap naturally on overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
      // A new drop takes priority over a clear in the same cycle.
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule : out_port_fifo

// File: tb/tb_out_port_fifo.sv
// tb_out_port_fifo
// Scoreboard bench for out_port_fifo. The stimulus tasks keep a queue-based
// reference of the FIFO contents and push every accepted nibble onto an
// expected-output queue. A separate monitor pops that queue whenever the DUT
// completes a valid/ready handshake.
module tb_out_port_fifo;
  import nibbler_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          loadOut;
  nibble_t       bus;
  logic          out_valid;
  nibble_t       out_data;
  logic          out_ready;
  logic [CW-1:0] count;
  logic          full;
  logic          overflow;
  logic          clr_ovf;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: current contents, expected output order, sticky flag.
  nibble_t model_q [$];
  nibble_t sb_q    [$];
  bit      model_ovf;

  out_port_fifo #(
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .loadOut   (loadOut),
    .bus       (bus),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: a handshake seen between edges is a pop at the next edge.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_pop", int'(out_data), -1);
      end else begin
        check("sb_order", int'(out_data), int'(sb_q.pop_front()));
      end
    end
  end

  task automatic checkOutput();
    check("count", int'(count), model_q.size());
    check("full", int'(full), int'(model_q.size() == DEPTH));
    check("overflow", int'(overflow), int'(model_ovf));
    check("out_valid", int'(out_valid), int'(model_q.size() != 0));
    if (model_q.size() != 0) begin
      check("out_data", int'(out_data), int'(model_q[0]));
    end else begin
      check("out_data_empty", int'(out_data), 0);
    end
  endtask

  // Drives one cycle and advances the model by the FIFO's rules, then checks.
  task automatic applyStimulus(input bit ld, input nibble_t d, input bit rdy, input bit clr);
    bit was_full;
    bit will_pop;
    loadOut   = ld;
    bus       = ld ? d : nibble_t'($urandom);
    out_ready = rdy;
    clr_ovf   = clr;
    was_full  = (model_q.size() == DEPTH);
    will_pop  = rdy && (model_q.size() != 0);
    if (will_pop) begin
      void'(model_q.pop_front());
    end
    if (ld && (!was_full || will_pop)) begin
      model_q.push_back(d);
      sb_q.push_back(d);
    end
    if (ld && was_full && !will_pop) begin
      model_ovf = 1'b1;
    end else if (clr) begin
      model_ovf = 1'b0;
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b0;
    loadOut   = 1'b0;
    bus       = 4'h0;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
    model_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput();
    @(negedge clk);
    reset = 1'b1;

    // Three pushes with the consumer stalled, then drain in order.
    applyStimulus(1'b1, 4'hA, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h5, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h3, 1'b0, 1'b0);
    check("three_pushed_count", int'(count), 3);
    check("three_pushed_head", int'(out_data), 4'hA);
    drain(3);
    check("drained_valid", int'(out_valid), 0);

    // Fill, overflow drop, drain, clear the sticky flag.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, nibble_t'(i), 1'b0, 1'b0);
    end
    check("fill_full", int'(full), 1);
    applyStimulus(1'b1, 4'hF, 1'b0, 1'b0);
    check("drop_overflow", int'(overflow), 1);
    drain(4);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
    check("clr_overflow", int'(overflow), 0);

    // Full FIFO with a simultaneous push and pop.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, nibble_t'(i), 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 4'h9, 1'b1, 1'b0);
    check("full_pushpop_count", int'(count), 4);
    check("full_pushpop_ovf", int'(overflow), 0);
    drain(4);

    // Empty FIFO with push and ready: no pop that cycle.
    applyStimulus(1'b1, 4'h6, 1'b1, 1'b0);
    check("empty_push_valid", int'(out_valid), 1);
    check("empty_push_data", int'(out_data), 4'h6);
    drain(1);

    // Continuous push/pop across pointer wrap.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, nibble_t'(i), 1'b1, 1'b0);
      check("stream_count", int'(count), 1);
    end
    drain(1);

    // Asynchronous reset pulse between clock edges.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, nibble_t'(4'h7 + i), 1'b0, 1'b0);
    end
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_count", int'(count), 0);
    check("async_reset_valid", int'(out_valid), 0);
    model_q.delete();
    sb_q.delete();
    model_ovf = 1'b0;
    #1;
    reset = 1'b1;
    applyStimulus(1'b1, 4'hC, 1'b0, 1'b0);
    check("post_reset_head", int'(out_data), 4'hC);
    drain(1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 99) < 60, nibble_t'($urandom),
                    $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 10);
    end
    drain(DEPTH);
    check("sb_leftover", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_out_port_fifo

// File: doc/out_port_fifo.md
OUT_PORT_FIFO -- requirements
Module: out_port_fifo

Interface
REQ-001 The block SHALL take parameter DEPTH, default 4, meaning FIFO entry count; legal values are powers of two from 2 to 16.
REQ-002 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  asynchronous active-low reset: 0 resets, 1 runs.
REQ-004 loadOut  input  1  CPU output strobe (microROM loadOut); 1 requests a push of bus.
REQ-005 bus  input  4  CPU data-bus nibble (tri-state bus value), sampled only when loadOut=1.
REQ-006 out_valid  output  1  head entry available to the external consumer.
REQ-007 out_data  output  4  head entry, first-word-fall-through.
REQ-008 out_ready  input  1  consumer accepts out_data this cycle.
REQ-009 count  output  $clog2(DEPTH)+1  number of occupied entries, 0..DEPTH.
REQ-010 full  output  1  count==DEPTH.
REQ-011 overflow  output  1  sticky flag: a push was dropped.
REQ-012 clr_ovf  input  1  synchronous clear of overflow.

Function
REQ-013 pop SHALL equal out_valid & out_ready; push SHALL equal loadOut & (~full | pop).
REQ-014 On push, bus SHALL be written at wr_ptr and wr_ptr incremented modulo DEPTH.
REQ-015 On pop, rd_ptr SHALL increment modulo DEPTH; pointers wrap with no extra latency.
REQ-016 count SHALL be incremented on push-only, decremented on pop-only, and held on push-and-pop or neither.
REQ-017 out_valid SHALL equal (count!=0); out_data SHALL equal mem[rd_ptr] combinationally from registered state, 0 when empty.
REQ-018 Latency: a nibble pushed at edge N SHALL appear on out_data with out_valid=1 immediately after edge N.
REQ-019 Empty plus loadOut: the push SHALL be accepted; no pop SHALL occur that cycle; out_valid SHALL rise after the edge.
REQ-020 Full plus loadOut plus pop in the same cycle: both SHALL occur; count SHALL stay DEPTH.
REQ-021 Full plus loadOut without pop: data SHALL be dropped, memory and pointers SHALL be unchanged, and overflow SHALL be set at the edge.
REQ-022 When clr_ovf and a new drop occur in the same cycle, overflow SHALL be 1 (set wins).
REQ-023 out_ready while empty SHALL be ignored, with no pointer or count change.
REQ-024 bus SHALL be X-tolerant: its value SHALL be irrelevant when loadOut=0.
REQ-025 FIFO order SHALL be strict: nibbles leave in push order, with no duplication or loss other than REQ-021 drops.

Reset
REQ-026 On reset=0, the block SHALL asynchronously clear wr_ptr, rd_ptr and count; out_valid=0, out_data=0, full=0, overflow=0.
REQ-027 Memory contents SHALL NOT need a reset; out_data gating under REQ-017 hides stale data.
REQ-028 Reset mid-stream SHALL discard all entries; the first push after release SHALL be the head.
REQ-029 Release SHALL be asynchronous; the first push SHALL be honoured at the first rising edge with reset=1.

Structure
REQ-030 The shared package nibbler_pkg SHALL hold typedef nibble_t (logic [3:0]) and constant OUT_FIFO_DEPTH=4; ports SHALL use nibble_t.
REQ-031 The storage array SHALL be one sub-module, nibble_regfile: one write port, one asynchronous read port, parameter DEPTH, no reset.
REQ-032 The pointer, count and flag logic SHALL reside in out_port_fifo; there SHALL be no other sub-modules.

Verification
REQ-033 The bench SHALL cover: reset, push 0xA, 0x5, 0x3 with out_ready=0 -> count=3, out_data=0xA; then out_ready=1 for 3 cycles -> 0xA, 0x5, 0x3 in order, then out_valid=0.
REQ-034 The bench SHALL cover: push 0x1..0x4 (full=1), push 0xF with out_ready=0 -> 0xF dropped, overflow=1, drain yields 0x1..0x4; then clr_ovf=1 -> overflow=0.
REQ-035 The bench SHALL cover: full FIFO, loadOut=1 with bus=0x9 and out_ready=1 in the same cycle -> 0x1 popped, count stays 4, overflow=0, 0x9 last out.
REQ-036 The bench SHALL cover: empty FIFO, loadOut=1 with bus=0x6 and out_ready=1 -> no pop that cycle, out_valid=1 and out_data=0x6 next cycle.
REQ-037 The bench SHALL cover: 10 cycles of continuous push/pop with bus=0..9 -> output 0..9 with pointer wrap, count constant at 1.
REQ-038 The bench SHALL cover: reset pulsed low mid-clock with count=3 -> count=0 and out_valid=0 immediately, not waiting for an edge; then push 0xC -> out_data=0xC.
